// File: rtl/string_match_pkg.sv
// Shared defaults, FSM state type and width helper for the multi-pattern string comparator.
package string_match_pkg;

  localparam int unsigned DefBusBytes = 4;
  localparam int unsigned DefMaxLen   = 17;
  localparam int unsigned DefNumPat   = 4;
  localparam int unsigned DefCntW     = 16;

  typedef enum logic [0:0] {
    StIdle,
    StInFrame
  } state_e;

  // Index width for n entries, never below one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_string_comparator_if.sv
// Stream, configuration and result signals of the string comparator.
interface multi_string_comparator_if #(
  parameter int unsigned BUS_BYTES = string_match_pkg::DefBusBytes,
  parameter int unsigned MAX_LEN   = string_match_pkg::DefMaxLen,
  parameter int unsigned NUM_PAT   = string_match_pkg::DefNumPat,
  parameter int unsigned CNT_W     = string_match_pkg::DefCntW
) ();

  localparam int unsigned SelW  = string_match_pkg::idx_w(NUM_PAT);
  localparam int unsigned AddrW = string_match_pkg::idx_w(MAX_LEN);
  localparam int unsigned LenW  = string_match_pkg::idx_w(MAX_LEN + 1);
  localparam int unsigned DataW = 8 * BUS_BYTES;

  logic               clear;
  logic               in_valid;
  logic               in_last;
  logic [DataW-1:0]   data_in;
  logic               cfg_we;
  logic [SelW-1:0]    cfg_sel;
  logic [AddrW-1:0]   cfg_addr;
  logic [7:0]         cfg_byte;
  logic               cfg_len_we;
  logic [LenW-1:0]    cfg_len;
  logic               cfg_busy;
  logic               out_valid;
  logic               out_last;
  logic [DataW-1:0]   data_out;
  logic [NUM_PAT-1:0] hit_vec;
  logic               frame_done;
  logic [NUM_PAT-1:0] frame_match_vec;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output clear, in_valid, in_last, data_in,
    output cfg_we, cfg_sel, cfg_addr, cfg_byte, cfg_len_we, cfg_len,
    input  cfg_busy, out_valid, out_last, data_out,
    input  hit_vec, frame_done, frame_match_vec, match_cnt
  );

  modport slave (
    input  clear, in_valid, in_last, data_in,
    input  cfg_we, cfg_sel, cfg_addr, cfg_byte, cfg_len_we, cfg_len,
    output cfg_busy, out_valid, out_last, data_out,
    output hit_vec, frame_done, frame_match_vec, match_cnt
  );

endinterface

// File: rtl/pattern_matcher.sv
// Matches one programmable pattern against the byte window at every end
// position inside the newest word.
module pattern_matcher #(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned MAX_LEN   = 17,
  parameter int unsigned LEN_W     = 5
) (
  input  logic [MAX_LEN+BUS_BYTES-2:0][7:0] win_i,     // index 0 oldest
  input  logic [MAX_LEN+BUS_BYTES-2:0]      win_vld_i,
  input  logic [MAX_LEN-1:0][7:0]           pat_i,     // index 0 first char
  input  logic [LEN_W-1:0]                  len_i,
  output logic                              hit_o
);

  localparam int Hist = int'(MAX_LEN + BUS_BYTES - 1);
  localparam int Nb   = int'(BUS_BYTES);
  localparam int Ml   = int'(MAX_LEN);

  logic m;

  // Every (end position, length) pair is compared with fixed indices; the
  // programmed length then selects which candidate counts.
  always_comb begin
    hit_o = 1'b0;
    m     = 1'b0;
    for (int e = 0; e < Nb; e++) begin
      for (int l = 1; l <= Ml; l++) begin
        m = 1'b1;
        for (int j = 0; j < l; j++) begin
          m = m & win_vld_i[Hist - Nb + e - l + 1 + j] &
              (win_i[Hist - Nb + e - l + 1 + j] == pat_i[j]);
        end
        if (int'(len_i) == l) begin
          hit_o = hit_o | m;
        end
      end
    end
  end

endmodule

// File: rtl/multi_string_comparator.sv
// Streams words through a one-cycle pipeline and flags any of NUM_PAT
// programmable byte patterns completing in each word, with per-frame results.
module multi_string_comparator
  import string_match_pkg::*;
#(
  parameter int unsigned BUS_BYTES = DefBusBytes,
  parameter int unsigned MAX_LEN   = DefMaxLen,
  parameter int unsigned NUM_PAT   = DefNumPat,
  parameter int unsigned CNT_W     = DefCntW
) (
  input logic                      clk,
  input logic                      rst,
  multi_string_comparator_if.slave bus
);

  localparam int unsigned Hist  = MAX_LEN + BUS_BYTES - 1;
  localparam int unsigned DataW = 8 * BUS_BYTES;
  localparam int unsigned LenW  = idx_w(MAX_LEN + 1);

  state_e                             state_q, state_d;
  logic [Hist-1:0][7:0]               hist_q, hist_d, win;
  logic [Hist-1:0]                    vld_q, vld_d, win_vld;
  logic [NUM_PAT-1:0][MAX_LEN-1:0][7:0] pat_q, pat_d;
  logic [NUM_PAT-1:0][LenW-1:0]       len_q, len_d;
  logic [NUM_PAT-1:0]                 hits, acc_q, acc_d, hit_q, hit_d, fmv_q, fmv_d;
  logic                               out_valid_q, out_valid_d;
  logic                               out_last_q, out_last_d;
  logic                               frame_done_q, frame_done_d;
  logic [DataW-1:0]                   data_q, data_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic                               cfg_ok;

  // Window as it looks once the current word has shifted in (newest byte last).
  always_comb begin
    win     = '0;
    win_vld = '0;
    for (int i = 0; i < int'(Hist - BUS_BYTES); i++) begin
      win[i]     = hist_q[i + int'(BUS_BYTES)];
      win_vld[i] = vld_q[i + int'(BUS_BYTES)];
    end
    for (int k = 0; k < int'(BUS_BYTES); k++) begin
      win[int'(Hist - BUS_BYTES) + k]     = bus.data_in[8 * (int'(BUS_BYTES) - 1 - k) +: 8];
      win_vld[int'(Hist - BUS_BYTES) + k] = 1'b1;
    end
  end

  for (genvar p = 0; p < NUM_PAT; p++) begin : g_pat
    pattern_matcher #(
      .BUS_BYTES (BUS_BYTES),
      .MAX_LEN   (MAX_LEN),
      .LEN_W     (LenW)
    ) u_match (
      .win_i     (win),
      .win_vld_i (win_vld),
      .pat_i     (pat_q[p]),
      .len_i     (len_q[p]),
      .hit_o     (hits[p])
    );
  end

  // Configuration writes land only between frames on cycles without a word,
  // so a word never sees a half-written pattern.
  always_comb begin
    cfg_ok = (state_q == StIdle) && !bus.in_valid;
    pat_d  = pat_q;
    len_d  = len_q;
    for (int p = 0; p < int'(NUM_PAT); p++) begin
      if (cfg_ok && (int'(bus.cfg_sel) == p)) begin
        if (bus.cfg_we) begin
          for (int a = 0; a < int'(MAX_LEN); a++) begin
            if (int'(bus.cfg_addr) == a) begin
              pat_d[p][a] = bus.cfg_byte;
            end
          end
        end
        if (bus.cfg_len_we && (int'(bus.cfg_len) <= int'(MAX_LEN))) begin
          len_d[p] = bus.cfg_len;
        end
      end
    end
  end

  // Frame FSM, history update, per-frame accumulation and output staging.
  always_comb begin
    state_d      = state_q;
    hist_d       = hist_q;
    vld_d        = vld_q;
    acc_d        = acc_q;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    data_d       = '0;
    hit_d        = '0;
    frame_done_d = 1'b0;
    fmv_d        = '0;
    cnt_d        = cnt_q;
    if (bus.clear) begin
      state_d = StIdle;
      vld_d   = '0;
      acc_d   = '0;
    end else if (bus.in_valid) begin
      hist_d      = win;
      vld_d       = win_vld;
      out_valid_d = 1'b1;
      out_last_d  = bus.in_last;
      data_d      = bus.data_in;
      hit_d       = hits;
      if (bus.in_last) begin
        // Invalidate history so the next frame cannot match across the boundary.
        state_d      = StIdle;
        vld_d        = '0;
        acc_d        = '0;
        frame_done_d = 1'b1;
        fmv_d        = acc_q | hits;
        if (((acc_q | hits) != '0) && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        state_d = StInFrame;
        acc_d   = acc_q | hits;
      end
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      hist_q       <= '0;
      vld_q        <= '0;
      pat_q        <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      hit_q        <= '0;
      fmv_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      data_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      hist_q       <= hist_d;
      vld_q        <= vld_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      acc_q        <= acc_d;
      hit_q        <= hit_d;
      fmv_q        <= fmv_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.cfg_busy        = (state_q == StInFrame);
  assign bus.out_valid       = out_valid_q;
  assign bus.out_last        = out_last_q;
  assign bus.data_out        = data_q;
  assign bus.hit_vec         = hit_q;
  assign bus.frame_done      = frame_done_q;
  assign bus.frame_match_vec = fmv_q;
  assign bus.match_cnt       = cnt_q;

endmodule
